sprite_mem_server: RTL and testbench

Memory-side responder for the sprite pixel fetch interface. It accepts a strobed read request (MEM_CLK, MEM_ADDR, MEM_SEL) from the pixel loader and translates the sprite-relative entry address into a flat address in the shared 16-bit sprite SRAM. It reads three consecutive 16-bit words, assembles them into one 48-bit two-pixel entry and holds it on DATA_OUT. The block sits between the pixel loader and the single external/on-chip sprite SRAM port.

---
 rtl/sprite_mem_pkg.sv | 51 +++++
 rtl/sprite_addr_calc.sv | 25 ++
 rtl/sprite_mem_server.sv | 130 +++++++++++++
 tb/tb_sprite_mem_server.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_mem_pkg.sv
// sprite_mem_pkg: shared sprite select encodings, sprite region map and server FSM states
// Contents:
//   SRAM_AW, ENTRY_W      : SRAM word address width and entry index width
//   sprite_sel_e          : MEM_SEL encodings shared with the pixel loader
//   state_e               : sprite_mem_server FSM states
//   sprite_base()         : first 48-bit entry of each sprite region
//   sprite_count()        : number of entries in each sprite region
package sprite_mem_pkg;
  localparam int SRAM_AW = 19;
  localparam int ENTRY_W = 18;
  typedef enum logic [2:0] {
    SEL_BG     = 3'd0,
    SEL_PWR    = 3'd1,
    SEL_RED    = 3'd2,
    SEL_GREEN  = 3'd3,
    SEL_BLUE   = 3'd4,
    SEL_YELLOW = 3'd5,
    SEL_WIN    = 3'd6,
    SEL_LOSE   = 3'd7
  } sprite_sel_e;
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CALC = 3'd1,
    S_RD0  = 3'd2,
    S_RD1  = 3'd3,
    S_RD2  = 3'd4,
    S_LAST = 3'd5
  } state_e;
  // Regions are packed back to back; LOSE ends at entry 168248.
  function automatic logic [ENTRY_W-1:0] sprite_base(input logic [2:0] sel);
    case (sprite_sel_e'(sel))
      SEL_BG:     return 18'd0;
      SEL_PWR:    return 18'd64800;
      SEL_RED:    return 18'd65000;
      SEL_GREEN:  return 18'd79112;
      SEL_BLUE:   return 18'd93224;
      SEL_YELLOW: return 18'd107336;
      SEL_WIN:    return 18'd121448;
      default:    return 18'd143048;
    endcase
  endfunction
  function automatic logic [15:0] sprite_count(input logic [2:0] sel);
    case (sprite_sel_e'(sel))
      SEL_BG:     return 16'd64800;
      SEL_PWR:    return 16'd200;
      SEL_WIN:    return 16'd21600;
      SEL_LOSE:   return 16'd25200;
      default:    return 16'd14112;
    endcase
  endfunction
endpackage

// File: rtl/sprite_addr_calc.sv
// sprite_addr_calc: sprite-relative entry to flat SRAM word address (base lookup, x3 multiply)
// Ports:
//   CLK, RESET : clock, synchronous active-high reset
//   load_i     : capture the computed word address into word_q_o
//   sel_i      : sprite select
//   addr_i     : entry index within the sprite
//   word_d_o   : combinational word address of the entry's first word
//   word_q_o   : registered word address
module sprite_addr_calc
  import sprite_mem_pkg::*;
(
  input  logic               CLK,
  input  logic               RESET,
  input  logic               load_i,
  input  logic [2:0]         sel_i,
  input  logic [15:0]        addr_i,
  output logic [SRAM_AW-1:0] word_d_o,
  output logic [SRAM_AW-1:0] word_q_o
);
  logic [ENTRY_W-1:0] entry;
  assign entry = sprite_base(sel_i) + ENTRY_W'(addr_i);
  // Three words per entry: entry*3 as a shift plus add.
  assign word_d_o = {entry, 1'b0} + SRAM_AW'(entry);
  always_ff @(posedge CLK) word_q_o <= RESET ? '0 : load_i ? word_d_o : word_q_o;
endmodule

// File: rtl/sprite_mem_server.sv
// sprite_mem_server: sprite SRAM responder assembling three 16-bit words into a 48-bit entry
// Ports:
//   CLK, RESET          : clock, synchronous active-high reset
//   MEM_CLK             : request strobe, each rising edge (sampled on CLK) is one request
//   MEM_ADDR, MEM_SEL   : entry index and sprite select of the request
//   DATA_OUT            : assembled entry, first pixel in [47:24]
//   DATA_VALID          : DATA_OUT holds the result of the latest request
//   BUSY                : fetch in progress
//   OVERRUN             : sticky, a request edge arrived while busy and was dropped
//   BOUNDS_ERR          : sticky, out-of-range entry requested (SPRITE_MEM_BOUNDS_CHECK_EN only)
//   SRAM_ADDR, SRAM_RD  : SRAM word address and read enable
//   SRAM_DQ             : SRAM read data, valid one cycle after SRAM_RD
// Build option SPRITE_MEM_BOUNDS_CHECK_EN: out-of-range requests skip the SRAM and
// complete one cycle after acceptance with DATA_OUT = 0.
module sprite_mem_server
  import sprite_mem_pkg::*;
(
  input  logic               CLK,
  input  logic               RESET,
  input  logic               MEM_CLK,
  input  logic [15:0]        MEM_ADDR,
  input  logic [2:0]         MEM_SEL,
  output logic [47:0]        DATA_OUT,
  output logic               DATA_VALID,
  output logic               BUSY,
  output logic               OVERRUN,
`ifdef SPRITE_MEM_BOUNDS_CHECK_EN
  output logic               BOUNDS_ERR,
`endif
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic               SRAM_RD,
  input  logic [15:0]        SRAM_DQ
);
  state_e             state_q;
  logic               prev_q;
  logic [15:0]        addr_q;
  logic [2:0]         sel_q;
  logic [15:0]        hi_q;
  logic [15:0]        mid_q;
  logic [SRAM_AW-1:0] word_d;
  logic [SRAM_AW-1:0] word_q;
  logic               req;
  assign req = MEM_CLK & ~prev_q;
`ifdef SPRITE_MEM_BOUNDS_CHECK_EN
  logic oob;
  assign oob = addr_q >= sprite_count(sel_q);
`endif
  sprite_addr_calc u_calc (
    .CLK      (CLK),
    .RESET    (RESET),
    .load_i   (state_q == S_CALC),
    .sel_i    (sel_q),
    .addr_i   (addr_q),
    .word_d_o (word_d),
    .word_q_o (word_q)
  );
  // SRAM_ADDR for the first read comes straight from the combinational
  // multiply so the read starts in the same cycle the word address is registered.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      prev_q     <= 1'b0;
      addr_q     <= '0;
      sel_q      <= '0;
      hi_q       <= '0;
      mid_q      <= '0;
      DATA_OUT   <= '0;
      DATA_VALID <= 1'b0;
      BUSY       <= 1'b0;
      OVERRUN    <= 1'b0;
`ifdef SPRITE_MEM_BOUNDS_CHECK_EN
      BOUNDS_ERR <= 1'b0;
`endif
      SRAM_ADDR  <= '0;
      SRAM_RD    <= 1'b0;
    end else begin
      prev_q <= MEM_CLK;
      if (req && state_q != S_IDLE) OVERRUN <= 1'b1;
      case (state_q)
        S_IDLE: if (req) begin
          addr_q     <= MEM_ADDR;
          sel_q      <= MEM_SEL;
          BUSY       <= 1'b1;
          DATA_VALID <= 1'b0;
          state_q    <= S_CALC;
        end
        S_CALC: begin
`ifdef SPRITE_MEM_BOUNDS_CHECK_EN
          if (oob) begin
            DATA_OUT   <= '0;
            DATA_VALID <= 1'b1;
            BUSY       <= 1'b0;
            BOUNDS_ERR <= 1'b1;
            state_q    <= S_IDLE;
          end else begin
            SRAM_RD   <= 1'b1;
            SRAM_ADDR <= word_d;
            state_q   <= S_RD0;
          end
`else
          SRAM_RD   <= 1'b1;
          SRAM_ADDR <= word_d;
          state_q   <= S_RD0;
`endif
        end
        S_RD0: begin
          SRAM_ADDR <= word_q + SRAM_AW'(1);
          state_q   <= S_RD1;
        end
        S_RD1: begin
          hi_q      <= SRAM_DQ;
          SRAM_ADDR <= word_q + SRAM_AW'(2);
          state_q   <= S_RD2;
        end
        S_RD2: begin
          mid_q   <= SRAM_DQ;
          SRAM_RD <= 1'b0;
          state_q <= S_LAST;
        end
        S_LAST: begin
          DATA_OUT   <= {hi_q, mid_q, SRAM_DQ};
          DATA_VALID <= 1'b1;
          BUSY       <= 1'b0;
          state_q    <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sprite_mem_server.sv
// tb_sprite_mem_server: directed scoreboard bench for sprite_mem_server
module tb_sprite_mem_server;
  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        MEM_CLK = 1'b0;
  logic [15:0] MEM_ADDR = '0;
  logic [2:0]  MEM_SEL = '0;
  logic [47:0] DATA_OUT;
  logic        DATA_VALID;
  logic        BUSY;
  logic        OVERRUN;
`ifdef SPRITE_MEM_BOUNDS_CHECK_EN
  logic        BOUNDS_ERR;
`endif
  logic [18:0] SRAM_ADDR;
  logic        SRAM_RD;
  logic [15:0] SRAM_DQ = '0;

  int n_checks = 0;
  int n_errors = 0;
  logic [47:0] exp_q[$];
  logic [18:0] rd_log[$];
  logic        dv_prev = 1'b0;

  sprite_mem_server dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .MEM_CLK    (MEM_CLK),
    .MEM_ADDR   (MEM_ADDR),
    .MEM_SEL    (MEM_SEL),
    .DATA_OUT   (DATA_OUT),
    .DATA_VALID (DATA_VALID),
    .BUSY       (BUSY),
    .OVERRUN    (OVERRUN),
`ifdef SPRITE_MEM_BOUNDS_CHECK_EN
    .BOUNDS_ERR (BOUNDS_ERR),
`endif
    .SRAM_ADDR  (SRAM_ADDR),
    .SRAM_RD    (SRAM_RD),
    .SRAM_DQ    (SRAM_DQ)
  );

  always #5 CLK = ~CLK;

  function automatic logic [15:0] sram_word(input logic [18:0] a);
    return a == 19'd0 ? 16'hAAAA : a == 19'd1 ? 16'hBBBB : a == 19'd2 ? 16'hCCCC
         : (a[15:0] ^ 16'h5A3C ^ {a[18:16], 13'h0});
  endfunction

  function automatic logic [18:0] exp_word(input int sel, input int addr);
    int b;
    case (sel)
      0: b = 0;
      1: b = 64800;
      2: b = 65000;
      3: b = 79112;
      4: b = 93224;
      5: b = 107336;
      6: b = 121448;
      default: b = 143048;
    endcase
    return 19'((b + addr) * 3);
  endfunction

  function automatic logic [47:0] exp_entry(input logic [18:0] w);
    return {sram_word(w), sram_word(w + 19'd1), sram_word(w + 19'd2)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // SRAM with one cycle read latency
  always @(posedge CLK) if (SRAM_RD) SRAM_DQ <= sram_word(SRAM_ADDR);

  // Log SRAM reads and score each completed entry against the queue.
  always @(negedge CLK) begin
    if (SRAM_RD) rd_log.push_back(SRAM_ADDR);
    if (DATA_VALID && !dv_prev) begin
      chk("dv_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) chk("data_out", DATA_OUT, exp_q.pop_front());
    end
    dv_prev = DATA_VALID;
  end

  task automatic request(input int sel, input int addr, input string tag);
    logic [18:0] w;
    int lat;
    w = exp_word(sel, addr);
    exp_q.push_back(exp_entry(w));
    rd_log.delete();
    MEM_SEL = 3'(sel);
    MEM_ADDR = 16'(addr);
    MEM_CLK = 1'b1;
    @(negedge CLK);
    chk({tag, "_busy"}, BUSY, 1);
    chk({tag, "_dv_drop"}, DATA_VALID, 0);
    MEM_CLK = 1'b0;
    lat = 0;
    while (!DATA_VALID && lat < 20) begin
      @(negedge CLK);
      lat++;
    end
    chk({tag, "_latency"}, lat, 5);
    chk({tag, "_busy_done"}, BUSY, 0);
    chk({tag, "_nreads"}, rd_log.size(), 3);
    if (rd_log.size() == 3) chk({tag, "_addrs"}, {rd_log[0], rd_log[1], rd_log[2]}, {w, w + 19'd1, w + 19'd2});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [18:0] w;
    repeat (3) @(negedge CLK);
    chk("rst_data_out", DATA_OUT, 0);
    chk("rst_dv", DATA_VALID, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_overrun", OVERRUN, 0);
    chk("rst_sram_rd", SRAM_RD, 0);
    chk("rst_sram_addr", SRAM_ADDR, 0);
    RESET = 1'b0;
    @(negedge CLK);
    request(0, 0, "bg0");
    chk("bg0_value", DATA_OUT, 48'hAAAABBBBCCCC);
    request(7, 25199, "lose_last");
    chk("lose_last_first_addr", exp_word(7, 25199), 19'd504741);
    request(2, 100, "red100");
    request(6, 21599, "win_last");
    request(1, 199, "pwr_last");
    request(5, 0, "yellow0");
    // Level held high: one fetch only, no overrun
    w = exp_word(3, 500);
    exp_q.push_back(exp_entry(w));
    rd_log.delete();
    MEM_SEL = 3'd3;
    MEM_ADDR = 16'd500;
    MEM_CLK = 1'b1;
    repeat (20) @(negedge CLK);
    MEM_CLK = 1'b0;
    @(negedge CLK);
    chk("hold_nreads", rd_log.size(), 3);
    chk("hold_overrun", OVERRUN, 0);
    chk("hold_dv", DATA_VALID, 1);
    // Second edge sampled at E2 of a fetch
    w = exp_word(2, 1234);
    exp_q.push_back(exp_entry(w));
    rd_log.delete();
    MEM_SEL = 3'd2;
    MEM_ADDR = 16'd1234;
    MEM_CLK = 1'b1;
    @(negedge CLK);
    MEM_CLK = 1'b0;
    @(negedge CLK);
    MEM_CLK = 1'b1;
    MEM_SEL = 3'd5;
    MEM_ADDR = 16'd42;
    @(negedge CLK);
    MEM_CLK = 1'b0;
    chk("ovr_flag", OVERRUN, 1);
    chk("ovr_busy", BUSY, 1);
    repeat (3) @(negedge CLK);
    chk("ovr_dv", DATA_VALID, 1);
    chk("ovr_nreads", rd_log.size(), 3);
    if (rd_log.size() == 3) chk("ovr_addr0", rd_log[0], w);
    // Reset while in RD1 aborts the fetch
    MEM_SEL = 3'd4;
    MEM_ADDR = 16'd7;
    MEM_CLK = 1'b1;
    @(negedge CLK);
    MEM_CLK = 1'b0;
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    chk("abort_sram_rd", SRAM_RD, 0);
    chk("abort_busy", BUSY, 0);
    chk("abort_dv", DATA_VALID, 0);
    chk("abort_data_out", DATA_OUT, 0);
    chk("abort_overrun", OVERRUN, 0);
    chk("abort_sram_addr", SRAM_ADDR, 0);
    RESET = 1'b0;
    @(negedge CLK);
    // Edge arriving as LAST completes is dropped
    w = exp_word(4, 14111);
    exp_q.push_back(exp_entry(w));
    MEM_SEL = 3'd4;
    MEM_ADDR = 16'd14111;
    MEM_CLK = 1'b1;
    @(negedge CLK);
    MEM_CLK = 1'b0;
    repeat (4) @(negedge CLK);
    MEM_CLK = 1'b1;
    @(negedge CLK);
    chk("last_edge_dv", DATA_VALID, 1);
    chk("last_edge_overrun", OVERRUN, 1);
    @(negedge CLK);
    chk("last_edge_no_accept", BUSY, 0);
    chk("last_edge_dv_hold", DATA_VALID, 1);
    MEM_CLK = 1'b0;
    @(negedge CLK);
    request(0, 64799, "bg_last");
`ifdef SPRITE_MEM_BOUNDS_CHECK_EN
    exp_q.push_back(48'h0);
    rd_log.delete();
    MEM_SEL = 3'd1;
    MEM_ADDR = 16'd200;
    MEM_CLK = 1'b1;
    @(negedge CLK);
    MEM_CLK = 1'b0;
    chk("oob_busy", BUSY, 1);
    @(negedge CLK);
    chk("oob_dv", DATA_VALID, 1);
    chk("oob_data_out", DATA_OUT, 0);
    chk("oob_err", BOUNDS_ERR, 1);
    chk("oob_busy_done", BUSY, 0);
    repeat (3) @(negedge CLK);
    chk("oob_nreads", rd_log.size(), 0);
`endif
    repeat (2) @(negedge CLK);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
